// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder: pipelined Kogge-Stone prefix adder/subtractor.
// One register rank for operand preparation, one per prefix level, one for the result.
// Latency is LEVELS+1 edges from acceptance to out_valid; one beat per cycle.
// A single global advance signal shifts or holds every rank together.
// Optional macro KS_PIPE_OVF_EN builds the signed-overflow path; otherwise ovf is tied to 0.
module ks_pipe_adder #(
  parameter int unsigned BW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic          cin,
  input  logic          sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] sum,
  output logic          cout,
  output logic          ovf
);

  localparam int LEVELS = $clog2(BW);

  logic                      w_adv;
  logic [BW-1:0]             w_b;
  logic [BW-1:0]             w_p;
  logic [BW-1:0]             w_g;
  logic                      w_c0;
  logic [BW-1:0]             w_sum;
  logic                      w_cout;

  // Index 0 of w_gn/w_ppn is the stage-0 input; index k is the next value for level k.
  logic [LEVELS:0][BW-1:0]   w_gn;
  logic [LEVELS-1:0][BW-1:0] w_ppn;

  logic [LEVELS:0]           r_vld;
  logic [LEVELS:0][BW-1:0]   r_g;   // group generate after each level
  logic [LEVELS-1:0][BW-1:0] r_pp;  // group propagate; the last level never needs it
  logic [LEVELS:0][BW-1:0]   r_p;   // original bitwise propagate, needed for the sum
  logic [LEVELS:0]           r_c0;
  logic                      r_out_valid;
  logic [BW-1:0]             r_sum;
  logic                      r_cout;

  assign w_adv    = !r_out_valid | out_ready;
  assign in_ready = w_adv;

  // Subtraction is A + ~B + 1; cin only matters for addition.
  assign w_b  = sub ? ~B : B;
  assign w_c0 = sub | cin;
  assign w_p  = A ^ w_b;
  assign w_g  = A & w_b;

  // Folding c0 into bit 0 makes every Gpre[i] the true carry out of bit i.
  assign w_gn[0]  = {w_g[BW-1:1], w_g[0] | (w_p[0] & w_c0)};
  assign w_ppn[0] = w_p;

  // Shifting in zeros leaves bits below the span unchanged, i.e. they pass through.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int Span = 1 << (k - 1);
    assign w_gn[k] = r_g[k-1] | (r_pp[k-1] & (r_g[k-1] << Span));
    if (k < LEVELS) begin : g_pp
      assign w_ppn[k] = r_pp[k-1] & ((r_pp[k-1] << Span) | ~({BW{1'b1}} << Span));
    end
  end

  assign w_sum  = r_p[LEVELS] ^ {r_g[LEVELS][BW-2:0], r_c0[LEVELS]};
  assign w_cout = r_g[LEVELS][BW-1];

  // Main pipeline: clear on reset, otherwise shift every rank when advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld       <= '0;
      r_g         <= '0;
      r_pp        <= '0;
      r_p         <= '0;
      r_c0        <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else if (w_adv) begin
      r_vld       <= {r_vld[LEVELS-1:0], in_valid};
      r_g         <= w_gn;
      r_pp        <= w_ppn;
      r_p         <= {r_p[LEVELS-1:0], w_p};
      r_c0        <= {r_c0[LEVELS-1:0], w_c0};
      r_out_valid <= r_vld[LEVELS];
      r_sum       <= w_sum;
      r_cout      <= w_cout;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef KS_PIPE_OVF_EN
  logic [LEVELS:0] r_sa;
  logic [LEVELS:0] r_sb;
  logic            r_ovf;

  // Operand sign bits ride alongside the prefix ranks to the result rank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_sa  <= {r_sa[LEVELS-1:0], A[BW-1]};
      r_sb  <= {r_sb[LEVELS-1:0], w_b[BW-1]};
      r_ovf <= (r_sa[LEVELS] == r_sb[LEVELS]) & (w_sum[BW-1] != r_sa[LEVELS]);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Self-checking bench for ks_pipe_adder: table vectors and random beats through a
// scoreboard queue, plus latency, backpressure, mid-flight reset and width-sweep sequences.
module tb_ks_pipe_adder;

  localparam int BW = 16;
`ifdef KS_PIPE_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [BW-1:0] A, B, sum;

  ks_pipe_adder #(.BW(BW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  // Width-sweep instances share one stimulus bus and never stall.
  logic        wv, wcin, wsub;
  logic [63:0] wa, wb;
  logic        w2_ir, w2_ov, w2_co, w2_of;
  logic        w5_ir, w5_ov, w5_co, w5_of;
  logic        w64_ir, w64_ov, w64_co, w64_of;
  logic [1:0]  w2_s;
  logic [4:0]  w5_s;
  logic [63:0] w64_s;

  ks_pipe_adder #(.BW(2)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(wv), .in_ready(w2_ir), .A(wa[1:0]), .B(wb[1:0]),
    .cin(wcin), .sub(wsub), .out_valid(w2_ov), .out_ready(1'b1), .sum(w2_s),
    .cout(w2_co), .ovf(w2_of)
  );
  ks_pipe_adder #(.BW(5)) u_w5 (
    .clk(clk), .rst(rst), .in_valid(wv), .in_ready(w5_ir), .A(wa[4:0]), .B(wb[4:0]),
    .cin(wcin), .sub(wsub), .out_valid(w5_ov), .out_ready(1'b1), .sum(w5_s),
    .cout(w5_co), .ovf(w5_of)
  );
  ks_pipe_adder #(.BW(64)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(wv), .in_ready(w64_ir), .A(wa), .B(wb),
    .cin(wcin), .sub(wsub), .out_valid(w64_ov), .out_ready(1'b1), .sum(w64_s),
    .cout(w64_co), .ovf(w64_of)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;  // value when the overflow path is built
  } vec_t;

  vec_t vt [10];
  exp_t sb_q [$];
  int   ret_cyc [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} of A + B' + c0 at width w.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb);
    logic [64:0] mask, aa, bb, s;
    logic        o;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, (sb ? ~b : b)} & mask;
    s    = aa + bb + {64'd0, (sb | ci)};
    o    = OvfEn && (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {o, s[w], s[63:0] & mask[63:0]};
  endfunction

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
    logic [65:0] r;
    r = model(16, {48'd0, a}, {48'd0, b}, ci, sb);
    return '{sum: r[15:0], cout: r[64], ovf: r[65]};
  endfunction

  // Scoreboard: compare every retired result against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        ret_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got sum=%0h expected no result", sum);
        end else begin
          e = sb_q.pop_front();
          chk("sb_sum", {48'd0, sum}, {48'd0, e.sum});
          chk("sb_cout", {63'd0, cout}, {63'd0, e.cout});
          chk("sb_ovf", {63'd0, ovf}, {63'd0, e.ovf});
        end
      end
    end
  end

  // Drive one beat starting at a negedge; push its expectation once it will be accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic sb, input exp_t e);
    int g = 0;
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=0 expected 1");
    end else begin
      sb_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int g = 0; g < 100 && sb_q.size() != 0; g++) @(negedge clk);
    chk(name, 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Single beat into an idle pipe; lat = edges after acceptance until out_valid.
  task automatic measure_lat(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic sb);
    int lat = -1;
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1;
    chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    sb_q.push_back(model16(a, b, ci, sb));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat = k - 1;
        break;
      end
    end
    chk(name, 64'(lat), 64'd5);
  endtask

  task automatic sweep(input logic [63:0] a, input logic [63:0] b, input logic ci,
                       input logic sb);
    int          l2 = -1, l5 = -1, l64 = -1;
    logic [1:0]  s2 = '0;
    logic [4:0]  s5 = '0;
    logic [63:0] s64 = '0;
    logic        c2 = 0, c5 = 0, c64 = 0, o2 = 0, o5 = 0, o64 = 0;
    logic [65:0] r;
    wa = a; wb = b; wcin = ci; wsub = sb; wv = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) wv = 1'b0;
      #1;
      if (w2_ov && l2 < 0) begin l2 = k - 1; s2 = w2_s; c2 = w2_co; o2 = w2_of; end
      if (w5_ov && l5 < 0) begin l5 = k - 1; s5 = w5_s; c5 = w5_co; o5 = w5_of; end
      if (w64_ov && l64 < 0) begin l64 = k - 1; s64 = w64_s; c64 = w64_co; o64 = w64_of; end
    end
    chk("w2_latency", 64'(l2), 64'd2);
    chk("w5_latency", 64'(l5), 64'd4);
    chk("w64_latency", 64'(l64), 64'd7);
    r = model(2, a, b, ci, sb);
    chk("w2_sum", {62'd0, s2}, {62'd0, r[1:0]});
    chk("w2_cout_ovf", {62'd0, c2, o2}, {62'd0, r[64], r[65]});
    r = model(5, a, b, ci, sb);
    chk("w5_sum", {59'd0, s5}, {59'd0, r[4:0]});
    chk("w5_cout_ovf", {62'd0, c5, o5}, {62'd0, r[64], r[65]});
    r = model(64, a, b, ci, sb);
    chk("w64_sum", s64, r[63:0]);
    chk("w64_cout_ovf", {62'd0, c64, o64}, {62'd0, r[64], r[65]});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;
    exp_t        e;

    //         a         b         cin   sub   sum       cout  ovf
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[2] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[9] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    wv = 1'b0; wa = '0; wb = '0; wcin = 1'b0; wsub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {48'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);

    measure_lat("latency_bw16", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_drain("drain_latency");

    for (int i = 0; i < 10; i++) begin
      e = '{sum: vt[i].sum, cout: vt[i].cout, ovf: vt[i].ovf & OvfEn};
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, e);
    end
    wait_drain("drain_table");

    ret_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      send(ra, rb, rc, rs, model16(ra, rb, rc, rs));
    end
    wait_drain("drain_b2b");
    chk("b2b_count", 64'(ret_cyc.size()), 64'd20);
    if (ret_cyc.size() == 20) chk("b2b_consecutive", 64'(ret_cyc[19] - ret_cyc[0]), 64'd19);

    // Backpressure: six beats fill the five pipeline ranks plus the result rank.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      send(ra, rb, rc, rs, model16(ra, rb, rc, rs));
    end
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      A = 16'($urandom); B = 16'($urandom);
      #1;
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_sum", {48'd0, sum}, {48'd0, sb_q[0].sum});
      chk("stall_cout", {63'd0, cout}, {63'd0, sb_q[0].cout});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_backpressure");

    // Reset with three beats in flight: none of them may ever emerge.
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      send(ra, rb, 1'b0, 1'b0, model16(ra, rb, 1'b0, 1'b0));
    end
    rst = 1'b1;
    out_ready = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", {48'd0, sum}, 64'd0);
    chk("midrst_cout", {63'd0, cout}, 64'd0);
    chk("midrst_ovf", {63'd0, ovf}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    measure_lat("latency_after_rst", 16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_drain("drain_after_rst");

    sweep({48'd0, 16'hFFFF}, 64'd1, 1'b0, 1'b0);
    sweep(64'd5, 64'd7, 1'b1, 1'b1);
    sweep(64'd7, 64'd5, 1'b1, 1'b1);
    sweep({48'd0, 16'h7FFF}, 64'd1, 1'b0, 1'b0);
    sweep({48'd0, 16'h8000}, 64'd1, 1'b0, 1'b1);
    sweep({64{1'b1}}, 64'd1, 1'b0, 1'b0);
    sweep(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    sweep(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
